// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: handshake-driven J/K controller for an external JK flip-flop bank (mask/clear/set/toggle/count).
// Define JK_SEQ_WRAP_STOP_EN to end a count early when the masked bits reach all-ones (up) or all-zeros (down).
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_UP     = 3'd4;
  localparam logic [2:0] OP_DN     = 3'd5;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [LEN_W-1:0] r_rem;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  logic [WIDTH-1:0] w_t_up;
  logic [WIDTH-1:0] w_t_dn;
  logic [WIDTH-1:0] w_lm;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_is_count;
  logic             w_wrap_hit;
  logic             w_direct;

  // Carry chain spans every q_fb bit; the mask only gates which bits are driven.
  always_comb begin
    w_t_up = '0;
    w_t_dn = '0;
    w_lm   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_lm      = WIDTH'((1 << i) - 1);
      w_t_up[i] = ((q_fb & w_lm) == w_lm);
      w_t_dn[i] = ((q_fb & w_lm) == '0);
    end
  end

  assign w_is_count = (r_op == OP_UP) || (r_op == OP_DN);
  assign w_direct   = (((cmd_op == OP_UP) || (cmd_op == OP_DN)) && (cmd_len == '0)) ||
                      (cmd_op == OP_NOP) || (cmd_op > OP_DN);

`ifdef JK_SEQ_WRAP_STOP_EN
  assign w_wrap_hit = (r_state == S_EXEC) &&
                      (((r_op == OP_UP) && ((q_fb & r_mask) == r_mask)) ||
                       ((r_op == OP_DN) && ((q_fb & r_mask) == '0)));
`else
  assign w_wrap_hit = 1'b0;
`endif

  always_comb begin
    w_j = '0;
    w_k = '0;
    if ((r_state == S_EXEC) && !w_wrap_hit) begin
      case (r_op)
        OP_CLEAR:  w_k = r_mask;
        OP_SET:    w_j = r_mask;
        OP_TOGGLE: begin w_j = r_mask;          w_k = r_mask;          end
        OP_UP:     begin w_j = w_t_up & r_mask; w_k = w_t_up & r_mask; end
        OP_DN:     begin w_j = w_t_dn & r_mask; w_k = w_t_dn & r_mask; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_mask  <= '0;
      r_rem   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_mask  <= cmd_mask;
            r_rem   <= cmd_len;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_direct) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_rem <= r_rem - 1'b1;
          if (w_wrap_hit) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_wrap  <= 1'b1;
          end else if (!w_is_count || (r_rem == LEN_W'(1))) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wrap      = r_wrap;
  assign j         = w_j;
  assign k         = w_k;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Randomized and directed bench for jk_bank_sequencer driving a behavioural 4-bit JK bank.
module tb_jk_bank_sequencer;
  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_mask = 4'd0;
  logic [7:0] cmd_len = 8'd0;
  logic [3:0] j, k;
  logic       cmd_ready, busy, done, wrap;
  logic [3:0] bank_q = 4'b0000;
  logic [3:0] cur_q = 4'b0000;
  int         checks = 0;
  int         failures = 0;

  always #5 clock = ~clock;

  // JK bank: q+ = j&~q | ~k&q
  always_ff @(posedge clock) bank_q <= (j & ~bank_q) | (~k & bank_q);

  jk_bank_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len), .q_fb(bank_q),
    .j(j), .k(k), .busy(busy), .done(done), .wrap(wrap)
  );

  // Reference: final q, number of EXEC cycles, wrap flag and first-cycle j/k.
  function automatic void model(input logic [2:0] op, input logic [3:0] q, input logic [3:0] m,
                                input logic [7:0] len, output logic [3:0] eq, output int ex,
                                output logic ew, output logic [3:0] ej0, output logic [3:0] ek0);
    logic [3:0] nb, tg;
    eq = q; ex = 0; ew = 1'b0; ej0 = 4'd0; ek0 = 4'd0;
    case (op)
      3'd1: begin eq = q & ~m; ex = 1; ek0 = m; end
      3'd2: begin eq = q | m;  ex = 1; ej0 = m; end
      3'd3: begin eq = q ^ m;  ex = 1; ej0 = m; ek0 = m; end
      3'd4, 3'd5: begin
        for (int s = 1; s <= int'(len); s++) begin
          ex = s;
`ifdef JK_SEQ_WRAP_STOP_EN
          if (((op == 3'd4) && ((eq & m) == m)) || ((op == 3'd5) && ((eq & m) == 4'd0))) begin
            ew = 1'b1;
            break;
          end
`endif
          nb = (op == 3'd4) ? eq + 4'd1 : eq - 4'd1;
          tg = (eq ^ nb) & m;
          if (s == 1) begin ej0 = tg; ek0 = tg; end
          eq = eq ^ tg;
        end
      end
      default: ;
    endcase
  endfunction

  // Drives one command and records what the DUT did around it.
  task automatic issue(input logic [2:0] op, input logic [3:0] m, input logic [7:0] len,
                       output int d_idx, output int d_cnt, output int rlow, output logic w_seen,
                       output logic to, output logic [3:0] j0, output logic [3:0] k0,
                       output logic [3:0] act);
    int   n;
    logic rdy_seen;
    d_idx = -1; d_cnt = 0; rlow = 0; w_seen = 1'b0; to = 1'b0;
    j0 = 4'd0; k0 = 4'd0; act = 4'd0; n = 0; rdy_seen = 1'b0;
    @(negedge clock);
    while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
    if (!cmd_ready) begin to = 1'b1; return; end
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_len = len;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (i == 0) begin cmd_valid = 1'b0; j0 = j; k0 = k; end
      act = act | j | k;
      if (!rdy_seen) begin
        if (!cmd_ready) rlow++;
        else rdy_seen = 1'b1;
      end
      if (wrap) w_seen = 1'b1;
      if (done) begin d_cnt++; if (d_idx < 0) d_idx = i; end
      if (d_idx >= 0 && i >= d_idx + 2) break;
    end
    if (d_idx < 0) to = 1'b1;
  endtask

  task automatic preload(input logic [3:0] v);
    int di, dc, rl; logic ws, to; logic [3:0] j0, k0, ac;
    issue(3'd2, 4'hF, 8'd0, di, dc, rl, ws, to, j0, k0, ac);
    issue(3'd1, ~v, 8'd0, di, dc, rl, ws, to, j0, k0, ac);
    cur_q = v;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    checks++; if ({j, k} !== 8'h00) begin failures++; $display("FAIL rst_jk got=%h exp=00", {j, k}); end
    checks++; if ({busy, done, wrap} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, done, wrap}); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int dc;
    preload(4'b0101);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_mask = 4'hF; cmd_len = 8'd0;
    @(negedge clock);
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_exec got=%b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if ({j, k} !== 8'h00) begin failures++; $display("FAIL mid_rst_jk got=%h exp=00", {j, k}); end
    checks++; if ({busy, cmd_ready} !== 2'b01) begin failures++; $display("FAIL mid_rst_busy_ready got=%b exp=01", {busy, cmd_ready}); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    dc = 0;
    repeat (6) begin @(negedge clock); if (done) dc++; end
    checks++; if (dc !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dc); end
    checks++; if (bank_q !== cur_q) begin failures++; $display("FAIL mid_q got=%b exp=%b", bank_q, cur_q); end
  endtask

  task automatic test_set_clear();
    int di, dc, rl, ex; logic ws, to, ew; logic [3:0] j0, k0, ac, eq, ej0, ek0;
    preload(4'b0000);
    model(3'd2, cur_q, 4'b1010, 8'd0, eq, ex, ew, ej0, ek0);
    issue(3'd2, 4'b1010, 8'd0, di, dc, rl, ws, to, j0, k0, ac);
    checks++; if (bank_q !== eq) begin failures++; $display("FAIL set_q got=%b exp=%b", bank_q, eq); end
    checks++; if ({j0, k0} !== {ej0, ek0}) begin failures++; $display("FAIL set_jk got=%h exp=%h", {j0, k0}, {ej0, ek0}); end
    checks++; if (di !== ex || dc !== 1 || to !== 1'b0) begin failures++; $display("FAIL set_done got=%0d/%0d exp=%0d/1", di, dc, ex); end
    cur_q = eq;
    model(3'd1, cur_q, 4'b0010, 8'd0, eq, ex, ew, ej0, ek0);
    issue(3'd1, 4'b0010, 8'd0, di, dc, rl, ws, to, j0, k0, ac);
    checks++; if (bank_q !== eq) begin failures++; $display("FAIL clear_q got=%b exp=%b", bank_q, eq); end
    checks++; if ({j0, k0} !== {ej0, ek0}) begin failures++; $display("FAIL clear_jk got=%h exp=%h", {j0, k0}, {ej0, ek0}); end
    cur_q = eq;
  endtask

  task automatic test_toggle();
    int di, dc, rl, ex; logic ws, to, ew; logic [3:0] j0, k0, ac, eq, ej0, ek0;
    preload(4'b0101);
    model(3'd3, cur_q, 4'hF, 8'd0, eq, ex, ew, ej0, ek0);
    issue(3'd3, 4'hF, 8'd0, di, dc, rl, ws, to, j0, k0, ac);
    checks++; if (bank_q !== eq) begin failures++; $display("FAIL toggle_q got=%b exp=%b", bank_q, eq); end
    checks++; if (rl !== ex + 1) begin failures++; $display("FAIL toggle_ready_low got=%0d exp=%0d", rl, ex + 1); end
    cur_q = eq;
  endtask

  task automatic test_count();
    int di, dc, rl, ex; logic ws, to, ew; logic [3:0] j0, k0, ac, eq, ej0, ek0;
    preload(4'b1101);
    model(3'd4, cur_q, 4'hF, 8'd5, eq, ex, ew, ej0, ek0);
    issue(3'd4, 4'hF, 8'd5, di, dc, rl, ws, to, j0, k0, ac);
    checks++; if (bank_q !== eq) begin failures++; $display("FAIL up_q got=%b exp=%b", bank_q, eq); end
    checks++; if (di !== ex || dc !== 1) begin failures++; $display("FAIL up_done got=%0d/%0d exp=%0d/1", di, dc, ex); end
    checks++; if (ws !== ew) begin failures++; $display("FAIL up_wrap got=%b exp=%b", ws, ew); end
    preload(4'b0010);
    model(3'd5, cur_q, 4'hF, 8'd9, eq, ex, ew, ej0, ek0);
    issue(3'd5, 4'hF, 8'd9, di, dc, rl, ws, to, j0, k0, ac);
    checks++; if (bank_q !== eq) begin failures++; $display("FAIL dn_q got=%b exp=%b", bank_q, eq); end
    checks++; if (di !== ex || ws !== ew || rl !== ex + 1) begin failures++; $display("FAIL dn_timing got=%0d/%b/%0d exp=%0d/%b/%0d", di, ws, rl, ex, ew, ex + 1); end
    cur_q = eq;
  endtask

  task automatic test_nop();
    int di, dc, rl; logic ws, to; logic [3:0] j0, k0, ac;
    preload(4'b0110);
    issue(3'd5, 4'hF, 8'd0, di, dc, rl, ws, to, j0, k0, ac);
    checks++; if ({ac, bank_q} !== {4'd0, cur_q}) begin failures++; $display("FAIL len0_act_q got=%h exp=%h", {ac, bank_q}, {4'd0, cur_q}); end
    checks++; if (di !== 0 || dc !== 1 || ws !== 1'b0) begin failures++; $display("FAIL len0_done got=%0d/%0d/%b exp=0/1/0", di, dc, ws); end
    issue(3'd7, 4'hF, 8'd3, di, dc, rl, ws, to, j0, k0, ac);
    checks++; if ({ac, bank_q} !== {4'd0, cur_q}) begin failures++; $display("FAIL op7_act_q got=%h exp=%h", {ac, bank_q}, {4'd0, cur_q}); end
    checks++; if (di !== 0 || dc !== 1 || ws !== 1'b0) begin failures++; $display("FAIL op7_done got=%0d/%0d/%b exp=0/1/0", di, dc, ws); end
  endtask

  task automatic test_back_to_back();
    int gap, dn;
    logic [3:0] exp_q;
    preload(4'b0110);
    exp_q = (cur_q ^ 4'b0011) | 4'b1100;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_mask = 4'b0011; cmd_len = 8'd0;
    @(negedge clock);
    cmd_op = 3'd2; cmd_mask = 4'b1100;
    gap = -1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) begin gap = i + 1; break; end
      @(negedge clock);
    end
    checks++; if (gap !== 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", gap); end
    @(negedge clock);
    cmd_valid = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin dn = 1; break; end
      @(negedge clock);
    end
    @(negedge clock);
    checks++; if (dn !== 1 || bank_q !== exp_q) begin failures++; $display("FAIL b2b_q got=%b done=%0d exp=%b done=1", bank_q, dn, exp_q); end
    cur_q = exp_q;
  endtask

  task automatic test_random();
    int di, dc, rl, ex; logic ws, to, ew; logic [3:0] j0, k0, ac, eq, ej0, ek0;
    logic [2:0] op; logic [3:0] m; logic [7:0] len;
    preload(4'($urandom));
    for (int n = 0; n < 25; n++) begin
      op  = 3'($urandom_range(0, 7));
      m   = 4'($urandom);
      len = 8'($urandom_range(0, 10));
      model(op, cur_q, m, len, eq, ex, ew, ej0, ek0);
      issue(op, m, len, di, dc, rl, ws, to, j0, k0, ac);
      checks++;
      if ({to, bank_q, j0, k0} !== {1'b0, eq, ej0, ek0}) begin
        failures++;
        $display("FAIL rnd_q_jk n=%0d op=%0d m=%b len=%0d got=%h exp=%h", n, op, m, len, {to, bank_q, j0, k0}, {1'b0, eq, ej0, ek0});
      end
      checks++;
      if (di !== ex || dc !== 1 || rl !== ex + 1 || ws !== ew) begin
        failures++;
        $display("FAIL rnd_timing n=%0d got=%0d/%0d/%0d/%b exp=%0d/1/%0d/%b", n, di, dc, rl, ws, ex, ex + 1, ew);
      end
      cur_q = eq;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_set_clear();
    test_toggle();
    test_count();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
